// File: rtl/mux_scan_nto1.sv
// rtl/mux_scan_nto1.sv - registered N-to-1 word mux with manual select and dwell-timed auto-scan
// Output carries the word, its channel tag, a wrap pulse and an out-of-range load pulse.
module mux_scan_nto1 #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 16,
  parameter int SEL_W    = 4,
  parameter int DWELL    = 4
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [CHANNELS*WIDTH-1:0] D,
  input  logic [SEL_W-1:0]          S,
  input  logic                      LOAD,
  input  logic                      MODE,
  input  logic                      EN,
  output logic [WIDTH-1:0]          Z,
  output logic [SEL_W-1:0]          ZSEL,
  output logic                      VALID,
  output logic                      WRAP,
  output logic                      ERR
);
  localparam int               NSLOT      = 1 << SEL_W;
  localparam logic [SEL_W-1:0] LAST_CH    = SEL_W'(CHANNELS - 1);
  localparam logic [15:0]      LAST_DWELL = 16'(DWELL - 1);

  logic [WIDTH-1:0] w_ch [NSLOT];
  logic             w_s_ok;
  logic             w_load_ok;
  logic             w_expire;
  logic             w_at_last;
  logic [SEL_W-1:0] w_sel_next;

  logic [SEL_W-1:0] r_sel;
  logic [15:0]      r_dwell_cnt;
  logic [WIDTH-1:0] r_z;
  logic [SEL_W-1:0] r_zsel;
  logic             r_valid;
  logic             r_wrap;
  logic             r_err;

  // Unused select codes read as zero; r_sel never reaches them anyway.
  for (genvar k = 0; k < NSLOT; k++) begin : g_ch
    if (k < CHANNELS) begin : g_used
      assign w_ch[k] = D[k*WIDTH +: WIDTH];
    end else begin : g_pad
      assign w_ch[k] = '0;
    end
  end

  assign w_s_ok     = (32'(S) < 32'(CHANNELS));
  assign w_load_ok  = LOAD && w_s_ok;
  assign w_expire   = MODE && (r_dwell_cnt == LAST_DWELL);
  assign w_at_last  = (r_sel == LAST_CH);
  assign w_sel_next = w_at_last ? '0 : r_sel + 1'b1;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sel       <= '0;
      r_dwell_cnt <= '0;
      r_z         <= '0;
      r_zsel      <= '0;
      r_valid     <= 1'b0;
      r_wrap      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
      if (EN) begin
        r_z     <= w_ch[r_sel];
        r_zsel  <= r_sel;
        r_valid <= 1'b1;
        // An accepted load pre-empts dwell expiry and restarts the dwell.
        if (w_load_ok) begin
          r_sel       <= S;
          r_dwell_cnt <= '0;
        end else if (w_expire) begin
          r_sel       <= w_sel_next;
          r_dwell_cnt <= '0;
          r_wrap      <= w_at_last;
        end else if (MODE) begin
          r_dwell_cnt <= r_dwell_cnt + 16'd1;
        end else begin
          r_dwell_cnt <= '0;
        end
        if (LOAD && !w_s_ok) begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign Z     = r_z;
  assign ZSEL  = r_zsel;
  assign VALID = r_valid;
  assign WRAP  = r_wrap;
  assign ERR   = r_err;

endmodule

// File: tb/tb_mux_scan_nto1.sv
// tb/tb_mux_scan_nto1.sv - scoreboard bench for mux_scan_nto1 over four parameter sets
// Instances: 0=(16ch,dwell3) 1=(12ch,dwell1) 2=(16ch,dwell2) 3=(16ch,dwell4).
module tb_mux_scan_nto1;
  typedef struct packed {
    logic [3:0] z;
    logic [3:0] zsel;
    logic       valid;
    logic       wrap;
    logic       err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] d = '0;
  logic [3:0]  s = '0;
  logic        load = 1'b0;
  logic        mode = 1'b0;
  logic        en = 1'b1;

  logic [3:0] z_o    [4];
  logic [3:0] zsel_o [4];
  logic       valid_o[4];
  logic       wrap_o [4];
  logic       err_o  [4];

  int         n_checks = 0;
  int         n_err = 0;
  string      tname = "";
  int         which = 0;
  int         m_ch = 16;
  int         m_dw = 3;
  logic [3:0] m_sel = '0;
  int         m_left = 3;
  exp_t       m_last = '0;
  exp_t       q[$];
  int         wrap_seen = 0;
  logic       saw_oob = 1'b0;

  always #5 clk = ~clk;

  mux_scan_nto1 #(.WIDTH(4), .CHANNELS(16), .SEL_W(4), .DWELL(3)) u_a (
    .CLK(clk), .RST_N(rst_n), .D(d), .S(s), .LOAD(load), .MODE(mode), .EN(en),
    .Z(z_o[0]), .ZSEL(zsel_o[0]), .VALID(valid_o[0]), .WRAP(wrap_o[0]), .ERR(err_o[0]));
  mux_scan_nto1 #(.WIDTH(4), .CHANNELS(12), .SEL_W(4), .DWELL(1)) u_b (
    .CLK(clk), .RST_N(rst_n), .D(d[47:0]), .S(s), .LOAD(load), .MODE(mode), .EN(en),
    .Z(z_o[1]), .ZSEL(zsel_o[1]), .VALID(valid_o[1]), .WRAP(wrap_o[1]), .ERR(err_o[1]));
  mux_scan_nto1 #(.WIDTH(4), .CHANNELS(16), .SEL_W(4), .DWELL(2)) u_c (
    .CLK(clk), .RST_N(rst_n), .D(d), .S(s), .LOAD(load), .MODE(mode), .EN(en),
    .Z(z_o[2]), .ZSEL(zsel_o[2]), .VALID(valid_o[2]), .WRAP(wrap_o[2]), .ERR(err_o[2]));
  mux_scan_nto1 #(.WIDTH(4), .CHANNELS(16), .SEL_W(4), .DWELL(4)) u_d (
    .CLK(clk), .RST_N(rst_n), .D(d), .S(s), .LOAD(load), .MODE(mode), .EN(en),
    .Z(z_o[3]), .ZSEL(zsel_o[3]), .VALID(valid_o[3]), .WRAP(wrap_o[3]), .ERR(err_o[3]));

  task automatic use_dut(input int w);
    which = w;
    m_ch  = (w == 1) ? 12 : 16;
    m_dw  = (w == 0) ? 3 : (w == 1) ? 1 : (w == 2) ? 2 : 4;
  endtask

  task automatic model_reset();
    m_sel  = '0;
    m_left = m_dw;
    m_last = '0;
    q.delete();
  endtask

  task automatic reset_all();
    en = 1'b1; load = 1'b0; mode = 1'b0; s = '0;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  // Predict the outputs of the coming edge, push them, then pop and compare after the edge.
  task automatic tick();
    exp_t e;
    exp_t got;
    exp_t want;
    if (en) begin
      e.z = d[int'(m_sel)*4 +: 4];
      e.zsel = m_sel; e.valid = 1'b1; e.wrap = 1'b0; e.err = 1'b0;
      if (load && int'(s) < m_ch) begin
        m_sel = s;
        m_left = m_dw;
      end else if (mode) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_left = m_dw;
          if (int'(m_sel) == m_ch - 1) begin
            m_sel = '0;
            e.wrap = 1'b1;
          end else begin
            m_sel = m_sel + 4'd1;
          end
        end
      end else begin
        m_left = m_dw;
      end
      if (load && int'(s) >= m_ch) e.err = 1'b1;
    end else begin
      e = m_last;
      e.wrap = 1'b0;
      e.err = 1'b0;
    end
    m_last = e;
    q.push_back(e);
    @(posedge clk);
    #1;
    want = q.pop_front();
    got = {z_o[which], zsel_o[which], valid_o[which], wrap_o[which], err_o[which]};
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s t=%0t: got z=%h zsel=%0d valid=%b wrap=%b err=%b, expected z=%h zsel=%0d valid=%b wrap=%b err=%b",
               tname, $time, got.z, got.zsel, got.valid, got.wrap, got.err,
               want.z, want.zsel, want.valid, want.wrap, want.err);
    end
    wrap_seen += int'(wrap_o[which]);
    if (int'(zsel_o[which]) >= m_ch) saw_oob = 1'b1;
  endtask

  task automatic test_reset();
    tname = "reset";
    use_dut(0);
    en = 1'b1; mode = 1'b0; load = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int w = 0; w < 4; w++) begin
      n_checks++;
      if ({z_o[w], zsel_o[w], valid_o[w], wrap_o[w], err_o[w]} !== 11'b0) begin
        n_err++;
        $display("FAIL reset_state dut%0d: got z=%h zsel=%0d valid=%b wrap=%b err=%b, expected all 0",
                 w, z_o[w], zsel_o[w], valid_o[w], wrap_o[w], err_o[w]);
      end
    end
    #1;
    rst_n = 1'b1;
    model_reset();
    d = 64'hFEDC_BA98_7654_3210;
    tname = "first_edge_valid";
    tick();
  endtask

  task automatic test_manual_sweep();
    tname = "manual_sweep";
    use_dut(0);
    reset_all();
    d = 64'hFEDC_BA98_7654_3210;
    for (int k = 0; k < 16; k++) begin
      s = 4'(k); load = 1'b1;
      tick();
      load = 1'b0;
      tick();
      tick();
    end
    tname = "manual_data_follow";
    for (int i = 0; i < 8; i++) begin
      d = {$urandom, $urandom};
      tick();
    end
  endtask

  task automatic test_scan();
    tname = "scan_dwell3";
    use_dut(0);
    reset_all();
    d = 64'hFEDC_BA98_7654_3210;
    mode = 1'b1;
    wrap_seen = 0;
    for (int i = 0; i < 97; i++) tick();
    n_checks++;
    if (wrap_seen != 2) begin
      n_err++;
      $display("FAIL scan_wrap_count: got %0d wraps, expected 2", wrap_seen);
    end
  endtask

  task automatic test_range();
    tname = "range_load";
    use_dut(1);
    reset_all();
    d = 64'h0000_BA98_7654_3210;
    s = 4'd5; load = 1'b1;
    tick();
    load = 1'b0;
    tick(); tick();
    s = 4'd13; load = 1'b1;
    tick();
    load = 1'b0;
    tick(); tick();
    tname = "range_scan";
    mode = 1'b1;
    saw_oob = 1'b0;
    wrap_seen = 0;
    for (int i = 0; i < 36; i++) tick();
    s = 4'd14; load = 1'b1;
    tick();
    load = 1'b0;
    tick(); tick();
    n_checks++;
    if (saw_oob !== 1'b0 || wrap_seen != 3) begin
      n_err++;
      $display("FAIL range_wrap: got oob=%b wraps=%0d, expected oob=0 wraps=3", saw_oob, wrap_seen);
    end
  endtask

  task automatic test_en_hold();
    int guard;
    tname = "en_hold";
    use_dut(2);
    reset_all();
    d = 64'h0123_4567_89AB_CDEF;
    mode = 1'b1;
    guard = 0;
    while (!(m_sel == 4'd6 && m_left == 1) && guard < 100) begin
      tick();
      guard++;
    end
    n_checks++;
    if (guard >= 100) begin
      n_err++;
      $display("FAIL en_hold_reach: got no channel 6 within %0d cycles, expected reach", guard);
    end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      load = (i == 2); s = 4'd2;
      tick();
    end
    load = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic test_collision();
    int guard;
    tname = "collision";
    use_dut(3);
    reset_all();
    d = 64'hFEDC_BA98_7654_3210;
    mode = 1'b1;
    guard = 0;
    while (!(m_sel == 4'd15 && m_left == 1) && guard < 200) begin
      tick();
      guard++;
    end
    n_checks++;
    if (guard >= 200) begin
      n_err++;
      $display("FAIL collision_reach: got no expiry at ch15 within %0d cycles, expected reach", guard);
    end
    wrap_seen = 0;
    s = 4'd3; load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    n_checks++;
    if (wrap_seen != 0) begin
      n_err++;
      $display("FAIL collision_wrap: got %0d wraps, expected 0", wrap_seen);
    end
  endtask

  task automatic test_async_reset();
    int guard;
    tname = "async_reset";
    use_dut(0);
    reset_all();
    d = 64'hFEDC_BA98_7654_3210;
    mode = 1'b1;
    guard = 0;
    while (m_sel != 4'd9 && guard < 100) begin
      tick();
      guard++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({z_o[0], zsel_o[0], valid_o[0], wrap_o[0], err_o[0]} !== 11'b0 || guard >= 100) begin
      n_err++;
      $display("FAIL async_reset_state: got z=%h zsel=%0d valid=%b guard=%0d, expected z=0 zsel=0 valid=0",
               z_o[0], zsel_o[0], valid_o[0], guard);
    end
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 10; i++) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_manual_sweep();
    test_scan();
    test_range();
    test_en_hold();
    test_collision();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mux_scan_nto1.md
Name: mux_scan_nto1

Overview:
- Parametrised, registered N-to-1 word multiplexer. It generalises the combinational 16-to-1 4-bit select mux.
- Adds a registered select and an auto-scan mode that steps through all channels, holding each channel for a programmable dwell time.
- Sits between banks of status/data words and a single-word consumer, such as a display driver or serial dumper.
- The output is registered, with a channel tag and a wrap pulse.

Parameters:
- WIDTH, 4: bits per channel word.
- CHANNELS, 16: number of input channels, 2..256.
- SEL_W, 4: select/index width; must satisfy 2**SEL_W >= CHANNELS.
- DWELL, 4: clock cycles each channel is held in scan mode, 1..65535.

Ports:
- CLK  input  1  single system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- D  input  CHANNELS*WIDTH  packed channel words; channel k occupies D[k*WIDTH +: WIDTH].
- S  input  SEL_W  requested channel index.
- LOAD  input  1  latch S into the select register.
- MODE  input  1  0 = manual select, 1 = auto-scan.
- EN  input  1  clock enable for all internal state.
- Z  output  WIDTH  registered selected word.
- ZSEL  output  SEL_W  channel index that Z currently carries.
- VALID  output  1  Z/ZSEL hold a sampled value.
- WRAP  output  1  one-cycle pulse when the scan steps from CHANNELS-1 to 0.
- ERR  output  1  one-cycle pulse when a LOAD is rejected as out of range.

Behaviour:
- Reset (RST_N low, asynchronous) forces:
  - sel_r=0, dwell_cnt=0.
  - Z=0, ZSEL=0, VALID=0, WRAP=0, ERR=0.
  - Release is synchronous to the next CLK edge.
- EN=0:
  - All registers hold, including Z, ZSEL, sel_r and dwell_cnt.
  - WRAP and ERR drive 0 on that edge.
  - LOAD is ignored.
- Output path, every EN=1 edge:
  - Z <= D[sel_r], ZSEL <= sel_r, VALID <= 1.
  - Latency: a new sel_r appears on Z/ZSEL one edge after sel_r changes, i.e. two edges after LOAD is sampled.
  - D is sampled every enabled edge, so data changes on the selected channel propagate with 1-cycle latency.
- VALID stays high until reset once it is set.
- LOAD (EN=1, any MODE):
  - If S < CHANNELS: sel_r <= S and dwell_cnt <= 0.
  - If S >= CHANNELS: sel_r unchanged and ERR pulses for 1 cycle.
- Manual mode (MODE=0):
  - sel_r changes only on LOAD.
  - dwell_cnt holds at 0.
- Scan mode (MODE=1):
  - dwell_cnt increments each enabled edge.
  - When dwell_cnt==DWELL-1: dwell_cnt <= 0 and sel_r advances.
  - sel_r advances as sel_r+1, or 0 if sel_r==CHANNELS-1.
  - On the wrap edge WRAP <= 1 for exactly one cycle.
  - DWELL=1 advances one channel per cycle.
- Priority: LOAD beats dwell expiry on the same edge.
  - The loaded value wins, dwell restarts from 0 and no WRAP is produced.
- Mode changes:
  - 1->0: sel_r frozen at its current value; dwell_cnt cleared.
  - 0->1: scanning starts from the current sel_r with dwell_cnt=0, so the first channel gets a full DWELL.
- Non-power-of-two CHANNELS:
  - Wrap is at CHANNELS-1, never at 2**SEL_W-1.
  - sel_r never holds an out-of-range index.
- Counter width: dwell_cnt is 16 bits wide; it never exceeds DWELL-1.
- Reset mid-scan returns to channel 0 in manual-equivalent state; MODE is re-sampled after release.

Test Plan:
- Manual sweep, defaults, D channel k = k, EN=1, MODE=0, LOAD with S=0..15 in turn -> two edges after each LOAD, Z==S and ZSEL==S; VALID=1 from the first enabled edge.
- Scan, CHANNELS=16, DWELL=3, MODE=1 from reset -> ZSEL sequence 0,0,0,1,1,1,...,15,15,15,0; WRAP high exactly one cycle at the 15->0 step, once per 48 cycles.
- Range check, CHANNELS=12, SEL_W=4, LOAD S=13 -> ERR pulses 1 cycle and ZSEL unchanged. Scan at DWELL=1 -> ZSEL wraps 11->0 with WRAP, never shows 12..15.
- EN hold: scan at DWELL=2, drop EN for 5 cycles mid-channel 6 -> Z/ZSEL/WRAP frozen. After EN returns, channel 6 completes its remaining dwell, then advances to 7.
- Collision: MODE=1, DWELL=4, assert LOAD S=3 on the edge where dwell expires at channel 15 -> sel_r=3, no WRAP, channel 3 held 4 full cycles.
- Async reset mid-scan: pulse RST_N low between clock edges at channel 9 -> Z=0, ZSEL=0, VALID=0 immediately without a clock. After release, the scan restarts at channel 0.
